// File: rtl/audio_sample_player.sv
// rtl/audio_sample_player.sv - sound-effect player: descriptor lookup, ROM streaming at a fixed rate, 1-bit PWM out
// Level return to the 8'h80 midpoint is deferred to the tick after a sample ends so the last sample lasts a full period.
module audio_sample_player #(
  parameter int SAMPLE_BITS   = 4,
  parameter int ROM_ADDR_BITS = 14,
  parameter int SAMPLE_PERIOD = 6250
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [SAMPLE_BITS-1:0]   SAMPLE_SELECT,
  input  logic                     TRIGGER,
  output logic [SAMPLE_BITS-1:0]   DESC_SELECT,
  input  logic [ROM_ADDR_BITS-1:0] DESC_START,
  input  logic [ROM_ADDR_BITS-1:0] DESC_END,
  output logic [ROM_ADDR_BITS-1:0] ROM_ADDR,
  input  logic [7:0]               ROM_DATA,
  output logic                     AUDIO_PWM,
  output logic                     PLAYING
);

  localparam int DIV_W = $clog2(SAMPLE_PERIOD);

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, FETCH} state_t;

  state_t                   state_q;
  logic [SAMPLE_BITS-1:0]   desc_select_q;
  logic [ROM_ADDR_BITS-1:0] addr_q, end_q, rom_addr_q;
  logic [ROM_ADDR_BITS-1:0] addr_inc;
  logic [7:0]               level_q;
  logic                     playing_q;
  logic                     restore_q;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [7:0]               pwm_cnt_q, pwm_cnt_d;
  logic                     pwm_q;
  logic                     tick;

  assign tick     = (div_q == DIV_W'(SAMPLE_PERIOD - 1));
  assign addr_inc = addr_q + ROM_ADDR_BITS'(1);

  always_comb begin
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end

  // Divider and PWM run in every state; TRIGGER never realigns the sample grid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q     <= '0;
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= (pwm_cnt_q < level_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      desc_select_q <= '0;
      addr_q        <= '0;
      end_q         <= '0;
      rom_addr_q    <= '0;
      level_q       <= 8'h80;
      playing_q     <= 1'b0;
      restore_q     <= 1'b0;
    end else begin
      if (tick && restore_q) begin
        level_q   <= 8'h80;
        restore_q <= 1'b0;
      end
      // A new trigger always wins, including over a pending return to midpoint.
      if (TRIGGER) begin
        desc_select_q <= SAMPLE_SELECT;
        restore_q     <= 1'b0;
        state_q       <= LOOKUP;
      end else begin
        case (state_q)
          IDLE: ;
          LOOKUP: begin
            addr_q <= DESC_START;
            end_q  <= DESC_END;
            if (DESC_START == DESC_END) begin
              playing_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              playing_q <= 1'b1;
              state_q   <= WAIT;
            end
          end
          WAIT: begin
            if (tick) begin
              rom_addr_q <= addr_q;
              state_q    <= FETCH;
            end
          end
          FETCH: begin
            level_q <= ROM_DATA;
            addr_q  <= addr_inc;
            if (addr_inc == end_q) begin
              playing_q <= 1'b0;
              restore_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign DESC_SELECT = desc_select_q;
  assign ROM_ADDR    = rom_addr_q;
  assign AUDIO_PWM   = pwm_q;
  assign PLAYING     = playing_q;

endmodule
